// File: rtl/multicycle_control.sv
// multicycle_control
// Main controller FSM for a multi-cycle CPU datapath with a 2-bit opcode:
// 00 R-type, 01 load, 10 store, 11 branch-if-equal.
// It steps through fetch, decode, execute, memory and write-back. It waits on
// the memory ready handshake, and it counts retired instructions for debug.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   en           run enable, sampled only in FETCH
//   opcode[1:0]  IR[1:0], valid from DECODE onward
//   zero         ALU zero flag (the datapath gates PCWriteCond with it)
//   mem_ready    memory completes the current read/write this cycle
//   PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, MemtoReg,
//   RegDst, RegWrite, ALUSrcA, ALUSrcB[1:0], ALUOp[1:0], PCSource
//                datapath control strobes (combinational from state/en/mem_ready)
//   state[3:0]   current state encoding (debug)
//   retired      retired-instruction counter, wraps
module multicycle_control #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             IRWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             PCSource,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_LOAD_WB   = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_EXEC_R    = 4'd6;
  localparam logic [3:0] S_R_WB      = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;

  logic [3:0]       state_reg;
  logic [3:0]       state_next;
  logic [CNT_W-1:0] retired_reg;
  logic             retire;

  // The branch decision belongs to the datapath (PC load = PCWrite |
  // (PCWriteCond & zero)), so the controller does not consume the flag.
  logic unused_zero;
  assign unused_zero = zero;

  // State register and retired counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_reg <= '0;
    end else if (retire) begin
      retired_reg <= retired_reg + CNT_W'(1);
    end
  end

  // Next-state logic. This block also flags the edge that completes an
  // instruction.
  always_comb begin
    state_next = S_FETCH;
    retire     = 1'b0;
    case (state_reg)
      S_FETCH:     state_next = (en && mem_ready) ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          2'b00:   state_next = S_EXEC_R;
          2'b01:   state_next = S_MEM_ADDR;
          2'b10:   state_next = S_MEM_ADDR;
          default: state_next = S_BRANCH;
        endcase
      end
      // Only loads and stores reach MEM_ADDR. Any other opcode here means the
      // IR changed underneath us, so the controller recovers to FETCH.
      S_MEM_ADDR: begin
        if (opcode == 2'b01) begin
          state_next = S_MEM_READ;
        end else if (opcode == 2'b10) begin
          state_next = S_MEM_WRITE;
        end else begin
          state_next = S_FETCH;
        end
      end
      S_MEM_READ:  state_next = mem_ready ? S_LOAD_WB : S_MEM_READ;
      S_LOAD_WB: begin
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      S_MEM_WRITE: begin
        state_next = mem_ready ? S_FETCH : S_MEM_WRITE;
        retire     = mem_ready;
      end
      S_EXEC_R:    state_next = S_R_WB;
      S_R_WB: begin
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      S_BRANCH: begin
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      default:     state_next = S_FETCH;
    endcase
  end

  // Output decode. Reset gates every strobe combinationally. This keeps the
  // FETCH decode (en=1) from reaching the datapath while reset is high.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 1'b0;
    if (!reset) begin
      case (state_reg)
        S_FETCH: begin
          if (en) begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;          // PC + 4
            IRWrite = mem_ready;
            PCWrite = mem_ready;
          end
        end
        S_DECODE: begin
          ALUSrcB = 2'b11;            // branch target into ALUOut
        end
        S_MEM_ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_MEM_READ: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_LOAD_WB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        S_MEM_WRITE: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        S_EXEC_R: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        S_R_WB: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 1'b1;
        end
        default: ;                    // illegal codes: all strobes low
      endcase
    end
  end

  assign state   = state_reg;
  assign retired = retired_reg;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  // Packed control bundle:
  // [14]PCWrite [13]PCWriteCond [12]IorD [11]IRWrite [10]MemRead [9]MemWrite
  // [8]MemtoReg [7]RegDst [6]RegWrite [5]ALUSrcA [4:3]ALUSrcB [2:1]ALUOp [0]PCSource
  localparam logic [14:0] C_ZERO = 15'b000000000000000;
  localparam logic [14:0] C_FR   = 15'b100110000001000; // FETCH, en=1, ready=1
  localparam logic [14:0] C_FW   = 15'b000010000001000; // FETCH, en=1, ready=0
  localparam logic [14:0] C_DEC  = 15'b000000000011000;
  localparam logic [14:0] C_MA   = 15'b000000000110000;
  localparam logic [14:0] C_MR   = 15'b001010000000000;
  localparam logic [14:0] C_LWB  = 15'b000000101000000;
  localparam logic [14:0] C_MW   = 15'b001001000000000;
  localparam logic [14:0] C_EXR  = 15'b000000000100100;
  localparam logic [14:0] C_RWB  = 15'b000000011000000;
  localparam logic [14:0] C_BR   = 15'b010000000100011;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  opcode = 2'b00;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;

  logic        PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite;
  logic        MemtoReg, RegDst, RegWrite, ALUSrcA, PCSource;
  logic [1:0]  ALUSrcB, ALUOp;
  logic [3:0]  state;
  logic [15:0] retired;

  logic [14:0] ctrl_w;
  logic [3:0]  state_w;
  logic [3:0]  retired_w;

  logic [14:0] ctrl;
  assign ctrl = {PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite,
                 MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

  int total = 0;
  int bad = 0;
  logic [15:0] exp_ret = 16'd0;

  always #5 clk = ~clk;

  multicycle_control #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .en(en), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .state(state), .retired(retired)
  );

  // Narrow-counter instance used to exercise the wrap-around in reasonable time.
  multicycle_control #(.CNT_W(4)) dut_w (
    .clk(clk), .reset(reset), .en(en), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready),
    .PCWrite(ctrl_w[14]), .PCWriteCond(ctrl_w[13]), .IorD(ctrl_w[12]),
    .IRWrite(ctrl_w[11]), .MemRead(ctrl_w[10]), .MemWrite(ctrl_w[9]),
    .MemtoReg(ctrl_w[8]), .RegDst(ctrl_w[7]), .RegWrite(ctrl_w[6]),
    .ALUSrcA(ctrl_w[5]), .ALUSrcB(ctrl_w[4:3]), .ALUOp(ctrl_w[2:1]),
    .PCSource(ctrl_w[0]), .state(state_w), .retired(retired_w)
  );

  task automatic test_reset();
    en = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      total++;
      if (state !== 4'd0 || ctrl !== C_ZERO || retired !== 16'd0) begin
        bad++;
        $display("FAIL reset_hold cyc%0d: got state=%0d ctrl=%b retired=%0d, want 0/0/0",
                 i, state, ctrl, retired);
      end
    end
    en = 1'b0;
    mem_ready = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      total++;
      if (state !== 4'd0 || ctrl !== C_ZERO || retired !== 16'd0) begin
        bad++;
        $display("FAIL idle cyc%0d: got state=%0d ctrl=%b retired=%0d, want 0/0/0",
                 i, state, ctrl, retired);
      end
    end
    $display("txn reset: state=%0d retired=%0d", state, retired);
  endtask

  task automatic test_rtype();
    logic [3:0]  es [5];
    logic [14:0] ec [5];
    es = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    ec = '{C_FR, C_DEC, C_EXR, C_RWB, C_ZERO};
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin
        en = 1'b1; mem_ready = 1'b1; opcode = 2'b00;
      end else if (i == 1) begin
        en = 1'b0;                     // no effect mid-instruction
      end
      #1;
      total++;
      if (state !== es[i] || ctrl !== ec[i]) begin
        bad++;
        $display("FAIL rtype cyc%0d: got state=%0d ctrl=%b, want state=%0d ctrl=%b",
                 i, state, ctrl, es[i], ec[i]);
      end
      if (i == 3) begin
        total++;
        if (retired !== exp_ret) begin
          bad++;
          $display("FAIL rtype_early_retire: got %0d, want %0d", retired, exp_ret);
        end
        exp_ret = exp_ret + 16'd1;
      end
      if (i < 4) @(negedge clk);
    end
    total++;
    if (retired !== exp_ret) begin
      bad++;
      $display("FAIL rtype_retired: got %0d, want %0d", retired, exp_ret);
    end
    $display("txn rtype: retired=%0d", retired);
  endtask

  task automatic test_load_wait();
    logic [3:0]  es [9];
    logic [14:0] ec [9];
    es = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
    ec = '{C_FR, C_DEC, C_MA, C_MR, C_MR, C_MR, C_MR, C_LWB, C_ZERO};
    for (int i = 0; i < 9; i++) begin
      case (i)
        0: begin en = 1'b1; mem_ready = 1'b1; opcode = 2'b01; end
        1: begin en = 1'b0; mem_ready = 1'b0; end
        6: mem_ready = 1'b1;
        7: mem_ready = 1'b0;
        default: ;
      endcase
      #1;
      total++;
      if (state !== es[i] || ctrl !== ec[i]) begin
        bad++;
        $display("FAIL load cyc%0d: got state=%0d ctrl=%b, want state=%0d ctrl=%b",
                 i, state, ctrl, es[i], ec[i]);
      end
      if (i < 8) @(negedge clk);
    end
    exp_ret = exp_ret + 16'd1;
    total++;
    if (retired !== exp_ret) begin
      bad++;
      $display("FAIL load_retired: got %0d, want %0d", retired, exp_ret);
    end
    $display("txn load: retired=%0d", retired);
  endtask

  task automatic test_store();
    logic [3:0]  es [6];
    logic [14:0] ec [6];
    es = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
    ec = '{C_FW, C_FR, C_DEC, C_MA, C_MW, C_ZERO};
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: begin en = 1'b1; mem_ready = 1'b0; opcode = 2'b10; end
        1: mem_ready = 1'b1;
        2: en = 1'b0;
        default: ;
      endcase
      #1;
      total++;
      if (state !== es[i] || ctrl !== ec[i]) begin
        bad++;
        $display("FAIL store cyc%0d: got state=%0d ctrl=%b, want state=%0d ctrl=%b",
                 i, state, ctrl, es[i], ec[i]);
      end
      if (i < 5) @(negedge clk);
    end
    exp_ret = exp_ret + 16'd1;
    total++;
    if (retired !== exp_ret) begin
      bad++;
      $display("FAIL store_retired: got %0d, want %0d", retired, exp_ret);
    end
    $display("txn store: retired=%0d", retired);
  endtask

  task automatic test_branch(input logic z);
    logic [3:0]  es [4];
    logic [14:0] ec [4];
    es = '{4'd0, 4'd1, 4'd8, 4'd0};
    ec = '{C_FR, C_DEC, C_BR, C_ZERO};
    zero = z;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin
        en = 1'b1; mem_ready = 1'b1; opcode = 2'b11;
      end else if (i == 1) begin
        en = 1'b0;
      end
      #1;
      total++;
      if (state !== es[i] || ctrl !== ec[i]) begin
        bad++;
        $display("FAIL branch_z%0d cyc%0d: got state=%0d ctrl=%b, want state=%0d ctrl=%b",
                 z, i, state, ctrl, es[i], ec[i]);
      end
      if (i < 3) @(negedge clk);
    end
    exp_ret = exp_ret + 16'd1;
    total++;
    if (retired !== exp_ret) begin
      bad++;
      $display("FAIL branch_z%0d_retired: got %0d, want %0d", z, retired, exp_ret);
    end
    $display("txn branch zero=%0d: retired=%0d", z, retired);
  endtask

  task automatic test_back_to_back();
    logic [3:0]  es [8];
    logic [14:0] ec [8];
    es = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 4'd1, 4'd8, 4'd0};
    ec = '{C_FR, C_DEC, C_EXR, C_RWB, C_FR, C_DEC, C_BR, C_ZERO};
    for (int i = 0; i < 8; i++) begin
      case (i)
        0: begin en = 1'b1; mem_ready = 1'b1; opcode = 2'b00; end
        4: opcode = 2'b11;
        7: en = 1'b0;
        default: ;
      endcase
      #1;
      total++;
      if (state !== es[i] || ctrl !== ec[i]) begin
        bad++;
        $display("FAIL b2b cyc%0d: got state=%0d ctrl=%b, want state=%0d ctrl=%b",
                 i, state, ctrl, es[i], ec[i]);
      end
      if (i < 7) @(negedge clk);
    end
    exp_ret = exp_ret + 16'd2;
    total++;
    if (retired !== exp_ret) begin
      bad++;
      $display("FAIL b2b_retired: got %0d, want %0d", retired, exp_ret);
    end
    $display("txn back_to_back: retired=%0d", retired);
  endtask

  task automatic test_reset_mid();
    logic [3:0]  es [5];
    logic [14:0] ec [5];
    es = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5};
    ec = '{C_FR, C_DEC, C_MA, C_MW, C_MW};
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin en = 1'b1; mem_ready = 1'b1; opcode = 2'b10; end
        1: mem_ready = 1'b0;
        default: ;
      endcase
      #1;
      total++;
      if (state !== es[i] || ctrl !== ec[i]) begin
        bad++;
        $display("FAIL rstmid cyc%0d: got state=%0d ctrl=%b, want state=%0d ctrl=%b",
                 i, state, ctrl, es[i], ec[i]);
      end
      if (i < 4) @(negedge clk);
    end
    // Assert reset between edges: the abandon must be immediate.
    reset = 1'b1;
    exp_ret = 16'd0;
    #1;
    total++;
    if (state !== 4'd0 || ctrl !== C_ZERO || retired !== 16'd0 || retired_w !== 4'd0) begin
      bad++;
      $display("FAIL rstmid_async: got state=%0d ctrl=%b retired=%0d/%0d, want 0/0/0/0",
               state, ctrl, retired, retired_w);
    end
    @(negedge clk);
    #1;
    total++;
    if (ctrl !== C_ZERO) begin
      bad++;
      $display("FAIL rstmid_gate: got ctrl=%b, want %b", ctrl, C_ZERO);
    end
    reset = 1'b0;
    en = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if (state !== 4'd0 || ctrl !== C_ZERO || retired !== 16'd0) begin
      bad++;
      $display("FAIL rstmid_release: got state=%0d ctrl=%b retired=%0d, want 0/0/0",
               state, ctrl, retired);
    end
    $display("txn reset_mid: state=%0d retired=%0d", state, retired);
  endtask

  task automatic test_wrap();
    // 15 branches fill the 4-bit counter and one more wraps it to zero.
    en = 1'b1; mem_ready = 1'b1; opcode = 2'b11; zero = 1'b1;
    repeat (45) @(negedge clk);
    #1;
    total++;
    if (retired_w !== 4'hF || retired !== 16'd15) begin
      bad++;
      $display("FAIL wrap_full: got %0d/%0d, want 15/15", retired_w, retired);
    end
    repeat (3) @(negedge clk);
    en = 1'b0;
    #1;
    total++;
    if (retired_w !== 4'h0 || retired !== 16'd16 || state_w !== 4'd0 || ctrl_w !== C_ZERO) begin
      bad++;
      $display("FAIL wrap_zero: got retired_w=%0d retired=%0d state_w=%0d ctrl_w=%b, want 0/16/0/0",
               retired_w, retired, state_w, ctrl_w);
    end
    $display("txn wrap: retired_w=%0d retired=%0d", retired_w, retired);
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load_wait();
    test_store();
    test_branch(1'b1);
    test_branch(1'b0);
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
